// File: rtl/uart_fpga_pkg.sv
// Shared types and helpers for the FPGA-side UART link (transmitter and receiver).
package uart_fpga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int PKT_WIDTH = 64;

    // Odd parity over the payload bits; the receiver uses the same function to check frames.
    function automatic logic odd_parity(input logic [PKT_WIDTH-2:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_fpga.sv
// UART transmitter: LSB-first frames with start/stop framing, optional parity in the MSB,
// and a one-word holding buffer so consecutive packets leave with no idle gap.
module uart_tx_fpga
    import uart_fpga_pkg::*;
#(
    parameter int WIDTH      = PKT_WIDTH,
    parameter int CLK_DIV    = 1,
    parameter int STOP_BITS  = 1,
    parameter int GEN_PARITY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             ld_tx_data,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_overflow
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W  = $clog2(WIDTH);
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    tx_state_t         state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [STOP_W-1:0] stop_reg, stop_next;
    logic [WIDTH-1:0]  shift_reg, shift_next;
    logic [WIDTH-1:0]  hold_reg, hold_next;
    logic              hold_valid_reg, hold_valid_next;
    logic              ready_reg, ready_next;
    logic              tx_out_reg, tx_out_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              ovf_reg, ovf_next;

    logic              par_bit;
    logic [WIDTH-1:0]  word_in;
    logic              bit_tick;
    logic              frame_end;
    logic              accept;
    logic              start_new;

    // Parity is taken from the word as presented on the loading edge.
    generate
        if (WIDTH <= PKT_WIDTH) begin : g_par_pkg
            assign par_bit = odd_parity((PKT_WIDTH-1)'(tx_data[WIDTH-2:0]));
        end else begin : g_par_wide
            assign par_bit = ~^tx_data[WIDTH-2:0];
        end
    endgenerate

    always_comb begin
        word_in = tx_data;
        if (GEN_PARITY != 0) begin
            word_in[WIDTH-1] = par_bit;
        end
    end

    always_comb begin
        state_next      = state_reg;
        baud_next       = baud_reg;
        idx_next        = idx_reg;
        stop_next       = stop_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        tx_out_next     = tx_out_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        ovf_next        = 1'b0;
        frame_end       = 1'b0;
        start_new       = 1'b0;
        bit_tick        = (baud_reg == BAUD_LAST);

        if (state_reg != IDLE) begin
            baud_next = bit_tick ? '0 : baud_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                baud_next = '0;
            end
            START: begin
                if (bit_tick) begin
                    state_next  = DATA;
                    idx_next    = '0;
                    tx_out_next = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next  = STOP;
                        stop_next   = '0;
                        tx_out_next = 1'b1;
                    end else begin
                        shift_next  = shift_reg >> 1;
                        idx_next    = idx_reg + 1'b1;
                        tx_out_next = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_reg == STOP_LAST) begin
                        frame_end = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        stop_next = stop_reg + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A load on the draining edge lands in the buffer that is being freed.
        accept   = ld_tx_data && (ready_reg || (frame_end && hold_valid_reg));
        ovf_next = ld_tx_data && !accept;

        if (frame_end) begin
            if (hold_valid_reg) begin
                shift_next      = hold_reg;
                hold_next       = '0;
                hold_valid_next = 1'b0;
                start_new       = 1'b1;
            end else begin
                state_next  = IDLE;
                busy_next   = 1'b0;
                tx_out_next = 1'b1;
            end
        end

        if (accept) begin
            if ((state_reg == IDLE) || (frame_end && !hold_valid_reg)) begin
                shift_next = word_in;
                start_new  = 1'b1;
            end else begin
                hold_next       = word_in;
                hold_valid_next = 1'b1;
            end
        end

        if (start_new) begin
            state_next  = START;
            baud_next   = '0;
            tx_out_next = 1'b0;
            busy_next   = 1'b1;
        end

        ready_next = !hold_valid_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            baud_reg       <= '0;
            idx_reg        <= '0;
            stop_reg       <= '0;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            ready_reg      <= 1'b1;
            tx_out_reg     <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            idx_reg        <= idx_next;
            stop_reg       <= stop_next;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            ready_reg      <= ready_next;
            tx_out_reg     <= tx_out_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            ovf_reg        <= ovf_next;
        end
    end

    assign tx_ready    = ready_reg;
    assign tx_out      = tx_out_reg;
    assign tx_busy     = busy_reg;
    assign tx_done     = done_reg;
    assign tx_overflow = ovf_reg;

endmodule

// File: tb/tb_uart_tx_fpga.sv
// Bench for uart_tx_fpga: two instances (CLK_DIV=1/STOP=1 and CLK_DIV=4/STOP=2) checked
// every cycle against a frame-timeline model, plus vector tables and hand-written sequences.
module tb_uart_tx_fpga;

    localparam int W  = 64;
    localparam int NI = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  tx_data [NI];
    logic [NI-1:0] ld;
    logic [NI-1:0] tx_ready, tx_out, tx_busy, tx_done, tx_overflow;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            uart_tx_fpga #(
                .WIDTH     (W),
                .CLK_DIV   ((gi == 0) ? 1 : 4),
                .STOP_BITS ((gi == 0) ? 1 : 2),
                .GEN_PARITY(1)
            ) dut (
                .clk        (clk),
                .reset_n    (reset_n),
                .tx_data    (tx_data[gi]),
                .ld_tx_data (ld[gi]),
                .tx_ready   (tx_ready[gi]),
                .tx_out     (tx_out[gi]),
                .tx_busy    (tx_busy[gi]),
                .tx_done    (tx_done[gi]),
                .tx_overflow(tx_overflow[gi])
            );
        end
    endgenerate

    int errors;
    int checks;
    bit chk_en;

    // Timeline model: one frame on the line, at most one word waiting.
    int            ecount;
    bit            m_active [NI];
    int            m_start  [NI];
    logic [W-1:0]  m_word   [NI];
    bit            m_queued [NI];
    logic [W-1:0]  m_qword  [NI];
    bit            m_done   [NI];
    bit            m_ovf    [NI];
    int            m_acc    [NI];

    typedef struct {
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [6];

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int frame_len(input int k);
        return (1 + W + ((k == 0) ? 1 : 2)) * div_of(k);
    endfunction

    // Bit 63 becomes 1 exactly when bits 62:0 hold an even number of ones.
    function automatic logic [W-1:0] adj(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = d;
        r[W-1] = (($countones(d[W-2:0]) % 2) == 0);
        return r;
    endfunction

    function automatic logic exp_line(input int k);
        int pos;
        int slot;
        if (!m_active[k]) return 1'b1;
        pos  = ecount - m_start[k];
        slot = pos / div_of(k);
        if (slot == 0) return 1'b0;
        if (slot <= W) return m_word[k][slot-1];
        return 1'b1;
    endfunction

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk);
            ecount++;
            for (int k = 0; k < NI; k++) begin
                if (!reset_n) begin
                    m_active[k] = 1'b0;
                    m_queued[k] = 1'b0;
                    m_done[k]   = 1'b0;
                    m_ovf[k]    = 1'b0;
                end else begin
                    m_done[k] = 1'b0;
                    m_ovf[k]  = 1'b0;
                    if (m_active[k] && (ecount == m_start[k] + frame_len(k))) begin
                        m_done[k] = 1'b1;
                        if (m_queued[k]) begin
                            m_start[k]  = ecount;
                            m_word[k]   = m_qword[k];
                            m_queued[k] = 1'b0;
                        end else begin
                            m_active[k] = 1'b0;
                        end
                    end
                    if (ld[k]) begin
                        if (!m_active[k]) begin
                            m_active[k] = 1'b1;
                            m_start[k]  = ecount;
                            m_word[k]   = adj(tx_data[k]);
                            m_acc[k]++;
                        end else if (!m_queued[k]) begin
                            m_queued[k] = 1'b1;
                            m_qword[k]  = adj(tx_data[k]);
                            m_acc[k]++;
                        end else begin
                            m_ovf[k] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic checker_loop();
        forever begin
            @(negedge clk);
            if (chk_en && reset_n) begin
                for (int k = 0; k < NI; k++) begin
                    check1($sformatf("cyc%0d_u%0d_out_rdy_busy_done_ovf", ecount, k),
                           {tx_out[k], tx_ready[k], tx_busy[k], tx_done[k], tx_overflow[k]},
                           {exp_line(k), !m_queued[k], m_active[k], m_done[k], m_ovf[k]});
                end
            end
        end
    endtask

    // Single frame on the CLK_DIV=1 instance from idle: capture its data bits and done timing.
    task automatic send_capture(input logic [63:0] d, input logic [63:0] exp, input string name);
        logic [63:0] w;
        int          first_done;
        w          = '0;
        first_done = -1;
        ld[0]      = 1'b1;
        tx_data[0] = d;
        tick();
        ld[0] = 1'b0;
        check1({name, "_start_bit"}, tx_out[0], 1'b0);
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (c <= W) w[c-1] = tx_out[0];
            if (c == W + 1) check1({name, "_stop_bit"}, tx_out[0], 1'b1);
            if (tx_done[0] && first_done < 0) first_done = c;
        end
        check1({name, "_word"}, w, exp);
        check1({name, "_done_cycle"}, first_done, 66);
    endtask

    initial begin
        logic [63:0] wa, wb, va, vb, vc;
        logic        s4 [0:280];
        int          first_done;
        int          target0, target1, budget;

        errors  = 0;
        checks  = 0;
        chk_en  = 1'b0;
        ecount  = 0;
        reset_n = 1'b0;
        ld      = '0;
        for (int k = 0; k < NI; k++) begin
            tx_data[k]  = '0;
            m_active[k] = 1'b0;
            m_queued[k] = 1'b0;
            m_done[k]   = 1'b0;
            m_ovf[k]    = 1'b0;
            m_acc[k]    = 0;
            m_start[k]  = 0;
            m_word[k]   = '0;
            m_qword[k]  = '0;
        end

        vecs[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
        vecs[1] = '{64'h0000_0000_0000_0003, 64'h8000_0000_0000_0003};
        vecs[2] = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
        vecs[5] = '{64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000};

        fork
            model_loop();
            checker_loop();
        join_none

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            for (int k = 0; k < NI; k++)
                check1($sformatf("idle%0d_u%0d", i, k),
                       {tx_out[k], tx_ready[k], tx_busy[k], tx_done[k], tx_overflow[k]}, 5'b11000);
        end

        for (int i = 0; i < 6; i++) begin
            send_capture(vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
            tick();
        end

        // Back-to-back A then B, third word C dropped while the buffer is full.
        va = 64'h0123_4567_89AB_CDEF;
        vb = 64'h0FED_CBA9_8765_4321;
        vc = 64'h5555_AAAA_1234_0F0F;
        wa = '0;
        wb = '0;
        ld[0] = 1'b1;
        tx_data[0] = va;
        tick();
        ld[0] = 1'b0;
        for (int c = 0; c <= 135; c++) begin
            if (c >= 1 && c <= 64)   wa[c-1]  = tx_out[0];
            if (c >= 67 && c <= 130) wb[c-67] = tx_out[0];
            if (c == 5)   check1("b2b_ready_after_B", tx_ready[0], 1'b0);
            if (c == 10)  check1("b2b_overflow_pulse", tx_overflow[0], 1'b1);
            if (c == 11)  check1("b2b_overflow_one_cycle", tx_overflow[0], 1'b0);
            if (c == 65)  check1("b2b_A_stop_ready_out", {tx_ready[0], tx_out[0]}, 2'b01);
            if (c == 66)  check1("b2b_A_exit_done_ready_out", {tx_done[0], tx_ready[0], tx_out[0]}, 3'b110);
            if (c == 132) check1("b2b_B_exit_done_busy", {tx_done[0], tx_busy[0]}, 2'b10);
            if (c == 134) check1("b2b_no_third_frame", {tx_busy[0], tx_out[0]}, 2'b01);
            ld[0]      = (c == 4) || (c == 9);
            tx_data[0] = (c == 4) ? vb : vc;
            tick();
        end
        ld[0] = 1'b0;
        check1("b2b_word_A", wa, 64'h8123_4567_89AB_CDEF);
        check1("b2b_word_B", wb, 64'h8FED_CBA9_8765_4321);

        // CLK_DIV=4, STOP_BITS=2 single frame.
        first_done = -1;
        ld[1] = 1'b1;
        tx_data[1] = 64'h0000_0000_0000_0001;
        tick();
        ld[1] = 1'b0;
        for (int c = 0; c <= 280; c++) begin
            s4[c] = tx_out[1];
            if (tx_done[1] && first_done < 0) first_done = c;
            tick();
        end
        check1("div4_start_slot", {s4[0], s4[1], s4[2], s4[3]}, 4'b0000);
        check1("div4_bit0_slot", {s4[4], s4[5], s4[6], s4[7]}, 4'b1111);
        check1("div4_bit1_first", s4[8], 1'b0);
        check1("div4_parity_slot", {s4[256], s4[257], s4[258], s4[259]}, 4'b0000);
        check1("div4_stop_slots", {s4[260], s4[261], s4[262], s4[263],
                                   s4[264], s4[265], s4[266], s4[267]}, 8'hFF);
        check1("div4_done_cycle", first_done, 268);

        // Random loads on both instances; the per-cycle model does the checking.
        target0 = m_acc[0] + 100;
        target1 = m_acc[1] + 20;
        budget  = 0;
        while ((m_acc[0] < target0 || m_acc[1] < target1) && budget < 20000) begin
            for (int k = 0; k < NI; k++) begin
                ld[k]      = ($urandom_range(0, 99) < 3);
                tx_data[k] = {$urandom, $urandom};
            end
            tick();
            budget++;
        end
        ld = '0;
        if (budget >= 20000) begin
            checks++;
            errors++;
            $display("FAIL rand_budget: accepted %0d/%0d words, required %0d/%0d", m_acc[0], m_acc[1], target0, target1);
        end
        budget = 0;
        while (tx_busy != '0 && budget < 1000) begin
            tick();
            budget++;
        end
        check1("rand_drain_idle", tx_busy, 2'b00);

        // Reset in the middle of the data phase.
        ld[0] = 1'b1;
        tx_data[0] = 64'hDEAD_BEEF_0000_FFFF;
        tick();
        ld[0] = 1'b0;
        repeat (20) tick();
        check1("pre_reset_busy", tx_busy[0], 1'b1);
        chk_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check1("async_reset_out_busy_ready", {tx_out[0], tx_busy[0], tx_ready[0]}, 3'b101);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk_en = 1'b1;
        check1("post_reset_idle", {tx_out[0], tx_ready[0], tx_busy[0], tx_done[0], tx_overflow[0]}, 5'b11000);
        send_capture(64'h0000_0000_0000_0003, 64'h8000_0000_0000_0003, "post_reset");
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fpga.md
Name: uart_tx_fpga

Overview:
- Simple UART transmitter for 64-bit packets on the FPGA side of the data link.
- Serializes each word LSB-first, framed by a start bit (0) and one or more stop bits (1), at a programmable number of clocks per bit.
- Optionally inserts the odd parity bit at MSB.
- Has a one-word holding buffer so packets can be sent back-to-back with no idle gap. With CLK_DIV=1 it drives uart_rx_fpga on the same clock.

Parameters:
- WIDTH, 64, packet width in bits (>=2).
- CLK_DIV, 1, clock cycles per serial bit (>=1).
- STOP_BITS, 1, stop bits per frame (>=1).
- GEN_PARITY, 1, when 1 bit WIDTH-1 is replaced by ~^tx_data[WIDTH-2:0]; when 0 the word is sent unmodified.

Ports:
- clk  input  1  transmit clock.
- reset_n  input  1  digital reset; asynchronous, active low.
- tx_data  input  WIDTH  word to send.
- ld_tx_data  input  1  load request; accepted on a rising edge where tx_ready=1.
- tx_ready  output  1  high when the holding buffer can accept a word.
- tx_out  output  1  serial output; idles high.
- tx_busy  output  1  high while a frame is on the line (START/DATA/STOP).
- tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit.
- tx_overflow  output  1  one-cycle pulse when ld_tx_data is asserted while tx_ready=0; that word is dropped.

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, tx_overflow=0.
  - FSM=IDLE; holding buffer and shift register are cleared.
  - A partial frame is abandoned.
- Registers: all outputs are registered. Parity is computed at load time on tx_data.
- FSM states: IDLE, START, DATA, STOP.
  - A baud counter (0..CLK_DIV-1) advances every cycle outside IDLE.
  - A "bit tick" occurs when the baud counter reaches CLK_DIV-1.
- IDLE:
  - ld_tx_data at edge E0 loads the (parity-adjusted) word directly into the shift register.
  - State goes to START; tx_out<=0 and tx_busy<=1 after E0; tx_ready stays 1.
  - The holding buffer is bypassed.
- START: after CLK_DIV cycles, state goes to DATA with bit index 0, and tx_out<=shift[0].
- DATA:
  - On each bit tick, shift right and increment the bit index.
  - After bit WIDTH-1 has been held for CLK_DIV cycles, state goes to STOP and tx_out<=1.
- STOP: held for STOP_BITS*CLK_DIV cycles. On the last cycle, tx_done pulses (visible after the exiting edge), then:
  - If the holding buffer is valid: move it to the shift register, clear it, and go directly to START (tx_out<=0). tx_ready returns to 1 on the same edge.
  - Otherwise go to IDLE and clear tx_busy.
- Holding buffer:
  - ld_tx_data while busy and the buffer is empty stores the word; tx_ready<=0 on the next edge.
  - ld_tx_data with tx_ready=0 is dropped and tx_overflow pulses. The buffer and the current frame are unaffected.
  - ld_tx_data on the same edge the buffer drains (STOP exit) is treated as tx_ready=1 as sampled; the new word is stored into the just-freed buffer.
- Frame length: (1+WIDTH+STOP_BITS)*CLK_DIV cycles. Back-to-back frames have no extra idle.
- Latency: with CLK_DIV=1 and IDLE, the start bit appears on tx_out in the cycle after the accepting edge.
- Widths:
  - The bit index is $clog2(WIDTH) bits and never wraps past WIDTH-1.
  - The baud counter is max(1,$clog2(CLK_DIV)) bits and wraps to 0 at CLK_DIV-1.
  - The stop counter counts STOP_BITS.

Decomposition:
- Shared package uart_fpga_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - localparam PKT_WIDTH=64;
  - function odd_parity(data[WIDTH-2:0]) returning ~^data, reused by the receiver check.
- No sub-module: the baud counter, bit counter, holding buffer and FSM live in one always_ff plus the parity function.

Test Plan:
- Reset, then idle 10 cycles -> tx_out=1, tx_ready=1, tx_busy=0, no pulses.
- CLK_DIV=1, GEN_PARITY=1, load 64'h0000_0000_0000_0001 -> tx_out sequence 0, 1, 0×62, parity 0, stop 1. tx_done pulses 66 cycles after load.
- Load 64'h0000_0000_0000_0003 -> bit63 sent as 1 (even ones in [62:0]).
- Back-to-back: load A=64'h0123_4567_89AB_CDEF, then B=64'h0FED_CBA9_8765_4321 while A is sending -> B's start bit follows A's stop bit with no gap; tx_ready is 0 from B's load until A's STOP exit.
- Third load while the buffer is full -> tx_overflow pulses once; the received words are A and B only.
- Loopback into uart_rx_fpga (same clk), 100 random words -> rx_data matches (parity-adjusted) and parity_error=0.
- CLK_DIV=4, STOP_BITS=2 -> each bit lasts 4 cycles and the frame lasts 268 cycles.
- Assert reset_n mid-DATA -> tx_out=1 immediately, tx_busy=0, and the next load starts a clean frame.
